// File: rtl/defuse_controller_pkg.sv
// Shared state encoding for the defuse game referee and the status display decoder.
package defuse_controller_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_WON      = 3'd4,
        ST_EXPLODED = 3'd5
    } state_t;

    function automatic logic is_active(input state_t st);
        return (st == ST_ARMED) || (st == ST_CHECK) || (st == ST_LOCKOUT);
    endfunction

endpackage

// File: rtl/defuse_controller_rise_edge_detect.sv
// Rising-edge detector: one-clock pulse on the first cycle a level input goes high.
module rise_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q_r;

    // Delay the input by one clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q_r <= 1'b0;
        end else begin
            d_q_r <= d;
        end
    end

    assign pulse = d & ~d_q_r;

endmodule

// File: rtl/defuse_controller.sv
// Defuse game referee: arms on pin configuration, judges tries, counts strikes, runs lockout.
module defuse_controller
    import defuse_controller_pkg::*;
#(
    parameter int A_W         = 4,
    parameter int B_W         = 3,
    parameter int MAX_STRIKES = 3,
    parameter int STRIKE_W    = 2,
    parameter int LOCKOUT_S   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick_1s,
    input  logic                pins_valid,
    input  logic [A_W-1:0]      a_pin,
    input  logic [B_W-1:0]      b_pin,
    input  logic [A_W-1:0]      guess_a,
    input  logic [B_W-1:0]      guess_b,
    input  logic                try_btn,
    input  logic                time_over,
    output logic                armed,
    output logic                lockout,
    output logic [STRIKE_W-1:0] strikes,
    output logic                game_won,
    output logic                exploded,
    output logic [2:0]          status
);

    localparam int CNT_W = $clog2(LOCKOUT_S + 1);

    state_t                 state_r, state_next_s;
    logic [STRIKE_W-1:0]    strikes_r, strikes_next_s, strikes_inc_s;
    logic [CNT_W-1:0]       count_r, count_next_s;
    logic [A_W+B_W-1:0]     guess_r;
    logic                   latch_en_s;
    logic                   try_edge_s;

    rise_edge_detect u_try_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (try_btn),
        .pulse   (try_edge_s)
    );

    assign strikes_inc_s = strikes_r + STRIKE_W'(1);

    // Next-state, strike and lockout-count decisions
    always_comb begin
        state_next_s   = state_r;
        strikes_next_s = strikes_r;
        count_next_s   = count_r;
        latch_en_s     = 1'b0;
        if (!pins_valid && (state_r != ST_IDLE)) begin
            state_next_s   = ST_IDLE;
            strikes_next_s = '0;
            count_next_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pins_valid) begin
                        state_next_s   = ST_ARMED;
                        strikes_next_s = '0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (time_over) begin
                        state_next_s = ST_EXPLODED;
                    end else if (try_edge_s) begin
                        state_next_s = ST_CHECK;
                        latch_en_s   = 1'b1;
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_CHECK: begin
                    if (guess_r == {a_pin, b_pin}) begin
                        state_next_s = ST_WON;
                    end else begin
                        strikes_next_s = strikes_inc_s;
                        count_next_s   = CNT_W'(LOCKOUT_S);
                        if (strikes_inc_s == STRIKE_W'(MAX_STRIKES)) begin
                            state_next_s = ST_EXPLODED;
                        end else begin
                            state_next_s = ST_LOCKOUT;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    // Tries are deliberately dropped here, not remembered for later
                    if (time_over) begin
                        state_next_s = ST_EXPLODED;
                    end else if (tick_1s && (count_r != '0)) begin
                        count_next_s = count_r - CNT_W'(1);
                        if (count_r == CNT_W'(1)) begin
                            state_next_s = ST_ARMED;
                        end else begin
                            state_next_s = ST_LOCKOUT;
                        end
                    end else begin
                        state_next_s = ST_LOCKOUT;
                    end
                end
                ST_WON:      state_next_s = ST_WON;
                ST_EXPLODED: state_next_s = ST_EXPLODED;
                default:     state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, counters and guess latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            strikes_r <= '0;
            count_r   <= '0;
            guess_r   <= '0;
        end else begin
            state_r   <= state_next_s;
            strikes_r <= strikes_next_s;
            count_r   <= count_next_s;
            if (latch_en_s) begin
                guess_r <= {guess_a, guess_b};
            end
        end
    end

    // Output flops decoded from the next state so they line up with state_r
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            lockout  <= 1'b0;
            game_won <= 1'b0;
            exploded <= 1'b0;
            status   <= 3'd0;
        end else begin
            armed    <= is_active(state_next_s);
            lockout  <= (state_next_s == ST_LOCKOUT);
            game_won <= (state_next_s == ST_WON);
            exploded <= (state_next_s == ST_EXPLODED);
            status   <= state_next_s;
        end
    end

    assign strikes = strikes_r;

endmodule

// File: tb/tb_defuse_controller.sv
// Directed self-checking bench for defuse_controller with hand-computed expectations.
module tb_defuse_controller;

    logic       clk;
    logic       reset_n;
    logic       tick_1s;
    logic       pins_valid;
    logic [3:0] a_pin;
    logic [2:0] b_pin;
    logic [3:0] guess_a;
    logic [2:0] guess_b;
    logic       try_btn;
    logic       time_over;
    logic       armed;
    logic       lockout;
    logic [1:0] strikes;
    logic       game_won;
    logic       exploded;
    logic [2:0] status;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int check_seen;

    defuse_controller #(
        .A_W(4), .B_W(3), .MAX_STRIKES(3), .STRIKE_W(2), .LOCKOUT_S(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_1s    (tick_1s),
        .pins_valid (pins_valid),
        .a_pin      (a_pin),
        .b_pin      (b_pin),
        .guess_a    (guess_a),
        .guess_b    (guess_b),
        .try_btn    (try_btn),
        .time_over  (time_over),
        .armed      (armed),
        .lockout    (lockout),
        .strikes    (strikes),
        .game_won   (game_won),
        .exploded   (exploded),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks, landing 1 ns after the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
    endtask

    // Press-and-release: after return the DUT has been in CHECK for one clock
    task automatic press(input logic [3:0] ga, input logic [2:0] gb);
        guess_a = ga;
        guess_b = gb;
        try_btn = 1'b1;
        step(1);
        try_btn = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"},   32'(status),   32'd0);
        check({tag, "_strikes"},  32'(strikes),  32'd0);
        check({tag, "_armed"},    32'(armed),    32'd0);
        check({tag, "_lockout"},  32'(lockout),  32'd0);
        check({tag, "_won"},      32'(game_won), 32'd0);
        check({tag, "_exploded"}, 32'(exploded), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; tick_1s = 1'b0; pins_valid = 1'b0;
        a_pin = 4'hA; b_pin = 3'h5; guess_a = 4'h0; guess_b = 3'h0;
        try_btn = 1'b0; time_over = 1'b0;
        step(2);
        check_all_zero("reset");
        reset_n = 1'b1;
        step(1);
        check("idle_hold", 32'(status), 32'd0);

        // 1: correct guess wins two clocks after the press edge
        pins_valid = 1'b1;
        step(1);
        check("arm_status", 32'(status), 32'd1);
        check("arm_armed",  32'(armed),  32'd1);
        press(4'hA, 3'h5);
        check("win_check_status", 32'(status),   32'd2);
        check("win_not_yet",      32'(game_won), 32'd0);
        step(1);
        check("win_won",    32'(game_won), 32'd1);
        check("win_status", 32'(status),   32'd4);
        check("win_armed",  32'(armed),    32'd0);
        time_over = 1'b1;
        step(2);
        check("won_ignores_timeout", 32'(status), 32'd4);
        time_over = 1'b0;

        // 2: wrong guess gives a strike and a two-tick lockout
        pins_valid = 1'b0;
        step(1);
        check_all_zero("rearm_idle");
        pins_valid = 1'b1;
        step(1);
        press(4'h3, 3'h5);
        step(1);
        check("wrong1_strikes", 32'(strikes), 32'd1);
        check("wrong1_lockout", 32'(lockout), 32'd1);
        check("wrong1_status",  32'(status),  32'd3);
        press(4'hA, 3'h5);
        step(1);
        check("lock_try_ignored", 32'(strikes), 32'd1);
        check("lock_try_status",  32'(status),  32'd3);
        tick();
        check("lock_tick1", 32'(status), 32'd3);
        tick();
        check("lock_tick2_status", 32'(status),  32'd1);
        check("lock_tick2_lock",   32'(lockout), 32'd0);
        step(2);
        check("no_queued_try", 32'(status), 32'd1);

        // 3: strikes 2 and 3, the third detonates
        press(4'h1, 3'h5);
        step(1);
        check("wrong2_strikes", 32'(strikes), 32'd2);
        tick();
        tick();
        check("wrong2_rearmed", 32'(status), 32'd1);
        press(4'hA, 3'h4);
        check("wrong3_in_check", 32'(exploded), 32'd0);
        step(1);
        check("boom_exploded", 32'(exploded), 32'd1);
        check("boom_strikes",  32'(strikes),  32'd3);
        check("boom_won",      32'(game_won), 32'd0);
        check("boom_status",   32'(status),   32'd5);
        check("boom_armed",    32'(armed),    32'd0);

        // 4: timeout beats a correct try in the same clock
        pins_valid = 1'b0;
        step(1);
        pins_valid = 1'b1;
        step(1);
        check("rearm_strikes0", 32'(strikes), 32'd0);
        guess_a = 4'hA; guess_b = 3'h5;
        try_btn = 1'b1; time_over = 1'b1;
        step(1);
        try_btn = 1'b0; time_over = 1'b0;
        check("race_status",   32'(status),   32'd5);
        check("race_won",      32'(game_won), 32'd0);
        check("race_exploded", 32'(exploded), 32'd1);

        // 5: holding the key for 100 clocks yields one CHECK
        pins_valid = 1'b0;
        step(1);
        pins_valid = 1'b1;
        step(1);
        guess_a = 4'h3; guess_b = 3'h5;
        try_btn = 1'b1;
        check_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick_1s = (i == 20 || i == 40) ? 1'b1 : 1'b0;
            step(1);
            if (status == 3'd2) check_seen++;
        end
        tick_1s = 1'b0;
        try_btn = 1'b0;
        check("hold_one_check", 32'(check_seen), 32'd1);
        check("hold_strikes",   32'(strikes),    32'd1);
        check("hold_status",    32'(status),     32'd1);
        step(1);
        press(4'h3, 3'h5);
        step(1);
        check("drop_pre_status", 32'(status), 32'd3);
        pins_valid = 1'b0;
        step(1);
        check_all_zero("drop_lockout");

        // Timeout during lockout beats a simultaneous tick
        pins_valid = 1'b1;
        step(1);
        press(4'h3, 3'h5);
        step(1);
        tick_1s = 1'b1; time_over = 1'b1;
        step(1);
        tick_1s = 1'b0; time_over = 1'b0;
        check("lock_timeout", 32'(status), 32'd5);

        // 6: async reset between edges during lockout
        pins_valid = 1'b0;
        step(1);
        pins_valid = 1'b1;
        step(1);
        press(4'h3, 3'h5);
        step(1);
        check("prereset_lockout", 32'(lockout), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #3;
        reset_n = 1'b1;
        step(1);
        check("post_reset_armed",   32'(status),  32'd1);
        check("post_reset_strikes", 32'(strikes), 32'd0);
        press(4'h3, 3'h5);
        step(1);
        check("post_reset_strike1", 32'(strikes), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
